wb_uart_tx_ctrl: RTL and testbench
==================================

WB_UART_TX_CTRL -- requirements
Module: wb_uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, byte queue entries (power of two, >=2).
REQ-002 SHALL have parameter UART_BASE, default 32'h0, byte address of the UART register block.
REQ-003 SHALL have parameter POLL_GAP, default 16, idle cycles between status polls when the UART TX FIFO is full.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 255, maximum cycles from strobe acceptance to ack.
REQ-005 SHALL have one clock; reset is asynchronous and active-low (clk_i, rst_ni).
REQ-006 clk_i  in  1  clock.
REQ-007 rst_ni  in  1  async active-low reset.
REQ-008 s_valid_i  in  1  byte offered; s_data_i  in  8  byte; s_ready_o  out  1  queue not full.
REQ-009 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  pipelined Wishbone master controls.
REQ-010 wb_adr_o  out  32  byte address; wb_dat_o  out  32  write data; wb_sel_o  out  4  always 4'b1111.
REQ-011 wb_ack_i, wb_stall_i, wb_err_i  in  1 each; wb_dat_i  in  32  read data.
REQ-012 q_empty_o  out  1  queue empty and no transfer pending; err_o  out  1  sticky bus fault; err_clr_i  in  1  clears err_o.

Function
REQ-013 Queue SHALL accept a byte on s_valid_i & s_ready_o; s_ready_o = (count < DEPTH); simultaneous push and pop at full SHALL not be accepted (ready reflects registered count).
REQ-014 FSM states: IDLE, POLL_REQ, POLL_WAIT, WR_REQ, WR_WAIT, BACKOFF.
REQ-015 IDLE -> POLL_REQ when queue non-empty; otherwise remain.
REQ-016 POLL_REQ: cyc=1, stb=1, we=0, adr=UART_BASE+4; stb held until cycle with wb_stall_i=0, then -> POLL_WAIT with stb=0, cyc=1.
REQ-017 POLL_WAIT: on ack, wb_dat_i[16]=1 (TX FIFO has space) -> WR_REQ, else -> BACKOFF; cyc drops on the ack cycle.
REQ-018 Ack arriving in the same cycle stb is accepted SHALL be honoured (skip the wait state's waiting).
REQ-019 WR_REQ: cyc=1, stb=1, we=1, adr=UART_BASE+12, dat={24'h0, queue head}; handshake as REQ-016 -> WR_WAIT.
REQ-020 WR_WAIT: on ack pop queue head, cyc drops, -> IDLE if queue now empty, else -> WR_REQ directly only if a fresh poll is not required; controller SHALL always re-poll (-> POLL_REQ).
REQ-021 BACKOFF: cyc=0 for POLL_GAP cycles, then -> POLL_REQ.
REQ-022 Timeout counter SHALL start at strobe acceptance; reaching ACK_TIMEOUT with no ack, or wb_err_i while cyc=1, SHALL drop cyc/stb, set err_o, -> BACKOFF; head byte SHALL not be popped.
REQ-023 err_o SHALL remain set until err_clr_i=1; set and clear in the same cycle -> set wins.
REQ-024 Acks arriving while cyc=0 SHALL be ignored.
REQ-025 q_empty_o = (count==0) & state==IDLE.
REQ-026 Byte order on the bus SHALL equal acceptance order; pointers wrap modulo DEPTH.

Reset
REQ-027 On rst_ni=0 all outputs SHALL go low immediately except s_ready_o=1 and q_empty_o=1; count=0, pointers=0, state=IDLE, err_o=0.
REQ-028 Reset mid-transfer SHALL abandon the cycle (cyc=0) and discard queued bytes.
REQ-029 Queue storage need not be reset.

Verification
REQ-030 Push 0x41,0x42; slave acks poll with bit16=1 each time -> two writes to UART_BASE+12 with dat 0x41 then 0x42, q_empty_o=1 after.
REQ-031 Poll returns bit16=0 twice then 1 -> exactly POLL_GAP idle cycles between polls, then one write; no byte lost.
REQ-032 Push DEPTH bytes with slave stalled -> s_ready_o=0 after 8th push; 9th offer not accepted; all 8 later written in order.
REQ-033 Slave never acks write -> cyc drops after ACK_TIMEOUT cycles, err_o=1, same byte retried after backoff; err_clr_i pulse -> err_o=0.
REQ-034 wb_stall_i=1 for 5 cycles on poll -> stb held 6 cycles with constant adr/we.
REQ-035 Assert rst_ni=0 during WR_WAIT -> cyc_o=0 same cycle, q_empty_o=1, no write after release.

Source files
------------

// File: rtl/wb_uart_tx_ctrl.sv
// rtl/wb_uart_tx_ctrl.sv - byte queue drained into a UART TX register over pipelined Wishbone
module wb_uart_tx_ctrl #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] UART_BASE   = 32'h0,
    parameter int          POLL_GAP    = 16,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    output logic        s_ready_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i,
    output logic        q_empty_o,
    output logic        err_o,
    input  logic        err_clr_i
);
    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW         = AW + 1;
    localparam int          TW         = $clog2(ACK_TIMEOUT + 1);
    localparam int          GW         = $clog2(POLL_GAP + 1);
    localparam logic [31:0] STATUS_ADR = UART_BASE + 32'd4;
    localparam logic [31:0] TXDATA_ADR = UART_BASE + 32'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_REQ,
        S_POLL_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_BACKOFF
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tmo;
    logic [GW-1:0] r_gap;
    logic          r_err;

    logic          w_push;
    logic          w_pop;
    logic          w_set_err;
    logic          w_last;
    logic          w_tmo_hit;
    logic          w_gap_done;
    logic          w_cyc;
    logic          w_stb;
    logic          w_we;
    logic [31:0]   w_adr;
    logic [31:0]   w_dat;
    logic [7:0]    w_head;
    logic          w_unused;

    // Only the TX-space flag of the status word matters here
    assign w_unused   = ^{wb_dat_i[31:17], wb_dat_i[15:0]};

    assign w_head     = r_mem[r_rptr];
    assign s_ready_o  = (r_count < CW'(DEPTH));
    assign w_push     = s_valid_i & s_ready_o;
    assign w_last     = (r_count == CW'(1)) & ~w_push;
    assign w_tmo_hit  = (r_tmo == TW'(ACK_TIMEOUT - 1));
    assign w_gap_done = (r_gap == GW'(POLL_GAP - 1));

    // Next state and bus drive; an ack in the accepting cycle is taken at once
    always_comb begin
        w_state_nxt = r_state;
        w_cyc       = 1'b0;
        w_stb       = 1'b0;
        w_we        = 1'b0;
        w_adr       = '0;
        w_dat       = '0;
        w_pop       = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_state_nxt = S_POLL_REQ;
            end
            S_POLL_REQ, S_POLL_WAIT: begin
                w_cyc = 1'b1;
                w_stb = (r_state == S_POLL_REQ);
                w_adr = STATUS_ADR;
                if (wb_err_i) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_BACKOFF;
                end else if ((r_state == S_POLL_REQ) && wb_stall_i) begin
                    w_state_nxt = S_POLL_REQ;
                end else if (wb_ack_i) begin
                    w_state_nxt = wb_dat_i[16] ? S_WR_REQ : S_BACKOFF;
                end else if (r_state == S_POLL_REQ) begin
                    w_state_nxt = S_POLL_WAIT;
                end else if (w_tmo_hit) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_BACKOFF;
                end
            end
            S_WR_REQ, S_WR_WAIT: begin
                w_cyc = 1'b1;
                w_stb = (r_state == S_WR_REQ);
                w_we  = 1'b1;
                w_adr = TXDATA_ADR;
                w_dat = {24'h0, w_head};
                if (wb_err_i) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_BACKOFF;
                end else if ((r_state == S_WR_REQ) && wb_stall_i) begin
                    w_state_nxt = S_WR_REQ;
                end else if (wb_ack_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_last ? S_IDLE : S_POLL_REQ;
                end else if (r_state == S_WR_REQ) begin
                    w_state_nxt = S_WR_WAIT;
                end else if (w_tmo_hit) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                if (w_gap_done) w_state_nxt = S_POLL_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage holds no reset; only pointers qualify its contents
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= s_data_i;
    end

    // Ack-wait and backoff counters run only inside their own states
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo <= '0;
            r_gap <= '0;
        end else begin
            r_tmo <= ((r_state == S_POLL_WAIT) || (r_state == S_WR_WAIT)) ? r_tmo + TW'(1) : '0;
            r_gap <= (r_state == S_BACKOFF) ? r_gap + GW'(1) : '0;
        end
    end

    // Sticky bus fault; a new fault beats a clear in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_err <= 1'b0;
        else if (w_set_err) r_err <= 1'b1;
        else if (err_clr_i) r_err <= 1'b0;
    end

    assign wb_cyc_o  = w_cyc;
    assign wb_stb_o  = w_stb;
    assign wb_we_o   = w_we;
    assign wb_adr_o  = w_adr;
    assign wb_dat_o  = w_dat;
    assign wb_sel_o  = 4'b1111;
    assign q_empty_o = (r_count == '0) && (r_state == S_IDLE);
    assign err_o     = r_err;

endmodule

// File: tb/tb_wb_uart_tx_ctrl.sv
// tb/tb_wb_uart_tx_ctrl.sv - scoreboard bench for wb_uart_tx_ctrl with a Wishbone slave model
module tb_wb_uart_tx_ctrl;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h4000_0100;
    localparam int          GAP   = 6;
    localparam int          TMO   = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h0;
    logic        s_ready;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0, wb_stall = 1'b0, wb_err = 1'b0;
    logic [31:0] wb_dat_i = 32'h0;
    logic        q_empty, err_o;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    wb_uart_tx_ctrl #(.DEPTH(DEPTH), .UART_BASE(BASE), .POLL_GAP(GAP), .ACK_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
        .wb_ack_i(wb_ack), .wb_stall_i(wb_stall), .wb_err_i(wb_err), .wb_dat_i(wb_dat_i),
        .q_empty_o(q_empty), .err_o(err_o), .err_clr_i(err_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: bytes must reach the bus in acceptance order
    logic [7:0] exp_q[$];

    // slave controls
    bit rand_mode = 0, wr_noack = 0, stall_forever = 0, err_once = 0;
    int stall_left = 0;
    bit poll_q[$];

    bit pend = 0, pend_we = 0, s_new = 1;
    int pend_dly = 0;

    task automatic respond(input bit we);
        bit st;
        if (we) begin
            if (!wr_noack) wb_ack = 1'b1;
        end else begin
            if (poll_q.size() != 0) st = poll_q.pop_front();
            else if (rand_mode)     st = ($urandom_range(0, 3) != 0);
            else                    st = 1'b1;
            wb_dat_i[16] = st;
            wb_ack = 1'b1;
        end
    endtask

    // Wishbone slave: decides stall/ack/err for the coming rising edge
    always @(negedge clk) begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = $urandom;
        if (!rst_n) begin
            pend = 0; s_new = 1;
        end else begin
            if (wb_cyc && !wb_stb && pend) begin
                if (pend_dly > 0) pend_dly--;
                else begin respond(pend_we); pend = 0; end
            end else if (!wb_cyc) begin
                pend = 0;
                if (rand_mode && $urandom_range(0, 7) == 0) wb_ack = 1'b1;
            end
            if (wb_stb) begin
                if (rand_mode && s_new) stall_left = $urandom_range(0, 3);
                if (stall_forever || stall_left > 0) begin
                    wb_stall = 1'b1;
                    s_new = 0;
                    if (!stall_forever) stall_left--;
                end else begin
                    s_new = 1;
                    if (err_once) begin wb_err = 1'b1; err_once = 0; end
                    else if (rand_mode && $urandom_range(0, 3) == 0) respond(wb_we);
                    else begin
                        pend = 1; pend_we = wb_we;
                        pend_dly = rand_mode ? int'($urandom_range(0, 3)) : 0;
                    end
                end
            end
        end
    end

    // monitor state
    int n_poll = 0, n_wr_acc = 0, n_wr = 0, n_tmo = 0, n_gap_chk = 0;
    bit out_v = 0, out_we = 0, expect_gap = 0, prev_cyc = 0, hold_bad = 0;
    int wait_cnt = 0, idle_run = 0, stb_len = 0;
    logic [31:0] hold_adr = 0;
    logic hold_we = 0;
    int stb_len_q[$];

    task automatic resolve(input bit we);
        if (we) begin
            n_wr++;
            void'(exp_q.pop_front());
        end else if (!wb_dat_i[16]) begin
            expect_gap = 1;
        end
    endtask

    // Monitor: samples what the DUT presents to the coming edge and scores it
    always begin
        @(negedge clk); #1;
        if (!rst_n) begin
            out_v = 0; expect_gap = 0; prev_cyc = 0; idle_run = 0; stb_len = 0;
        end else begin
            if (wb_cyc && !prev_cyc) begin
                if (expect_gap) begin
                    chk("backoff_gap", 32'(idle_run), 32'(GAP));
                    n_gap_chk++;
                    expect_gap = 0;
                end
                idle_run = 0;
            end
            if (!wb_cyc) idle_run++;
            prev_cyc = wb_cyc;

            if (out_v) begin
                if (!wb_cyc) begin
                    chk("ack_timeout_len", 32'(wait_cnt), 32'(TMO));
                    n_tmo++; out_v = 0; expect_gap = 1;
                end else if (wb_err) begin
                    out_v = 0; expect_gap = 1;
                end else if (wb_ack) begin
                    resolve(out_we); out_v = 0;
                end else begin
                    wait_cnt++;
                end
            end

            if (wb_stb) begin
                if (stb_len == 0) begin
                    hold_adr = wb_adr; hold_we = wb_we; hold_bad = 0;
                end else if (wb_adr !== hold_adr || wb_we !== hold_we) begin
                    hold_bad = 1;
                end
                stb_len++;
                if (!wb_stall) begin
                    chk("stb_hold_stable", 32'(hold_bad), 32'd0);
                    chk("sel", 32'(wb_sel), 32'hf);
                    stb_len_q.push_back(stb_len);
                    stb_len = 0;
                    if (wb_we) begin
                        n_wr_acc++;
                        chk("wr_adr", wb_adr, BASE + 32'd12);
                        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) chk("wr_data", wb_dat_o, {24'h0, exp_q[0]});
                    end else begin
                        n_poll++;
                        chk("poll_adr", wb_adr, BASE + 32'd4);
                    end
                    if (wb_err)      expect_gap = 1;
                    else if (wb_ack) resolve(wb_we);
                    else begin out_v = 1; out_we = wb_we; wait_cnt = 0; end
                end
            end else begin
                stb_len = 0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output bit ok);
        @(negedge clk);
        s_valid = 1'b1; s_data = b;
        ok = s_ready;
        @(posedge clk);
        if (ok) exp_q.push_back(b);
        #1 s_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [7:0] b);
        bit ok;
        int t;
        ok = 0; t = 0;
        while (!ok && t < 500) begin push_byte(b, ok); t++; end
        chk("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        @(negedge clk); #2;
        while (!(q_empty && exp_q.size() == 0 && !out_v) && t < bound) begin
            @(negedge clk); #2; t++;
        end
        chk("idle_reached", 32'(q_empty && exp_q.size() == 0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_acc, b_poll, b_gap, b_tmo, t;
        bit ok;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_qempty", 32'(q_empty), 32'd1);
        chk("rst_err", 32'(err_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // two bytes, poll always reports space
        b_wr = n_wr;
        push_wait(8'h41);
        push_wait(8'h42);
        wait_idle(2000);
        chk("t1_writes", 32'(n_wr - b_wr), 32'd2);

        // poll reports full twice
        b_wr = n_wr; b_poll = n_poll; b_gap = n_gap_chk;
        poll_q.push_back(1'b0); poll_q.push_back(1'b0);
        push_wait(8'h55);
        wait_idle(2000);
        chk("t2_polls", 32'(n_poll - b_poll), 32'd3);
        chk("t2_gaps", 32'(n_gap_chk - b_gap), 32'd2);
        chk("t2_writes", 32'(n_wr - b_wr), 32'd1);

        // fill the queue while the slave stalls
        b_wr = n_wr;
        stall_forever = 1;
        for (int i = 0; i < DEPTH; i++) begin
            push_byte(8'($urandom), ok);
            chk("t3_fill_accept", 32'(ok), 32'd1);
        end
        @(negedge clk); #1;
        chk("t3_ready_full", 32'(s_ready), 32'd0);
        push_byte(8'hEE, ok);
        chk("t3_ninth_rejected", 32'(ok), 32'd0);
        chk("t3_queued", 32'(exp_q.size()), 32'(DEPTH));
        stall_forever = 0;
        wait_idle(4000);
        chk("t3_writes", 32'(n_wr - b_wr), 32'(DEPTH));

        // five stall cycles on the poll
        stb_len_q.delete();
        stall_left = 5;
        push_wait(8'($urandom));
        wait_idle(2000);
        chk("t4_records", 32'(stb_len_q.size() >= 2), 32'd1);
        if (stb_len_q.size() >= 2) begin
            chk("t4_poll_stb_len", 32'(stb_len_q[0]), 32'd6);
            chk("t4_wr_stb_len", 32'(stb_len_q[1]), 32'd1);
        end

        // write never acked: timeout, error, retry of the same byte
        b_wr = n_wr; b_acc = n_wr_acc; b_tmo = n_tmo;
        wr_noack = 1;
        push_wait(8'h77);
        t = 0;
        while (n_tmo == b_tmo && t < 500) begin @(negedge clk); #2; t++; end
        wr_noack = 0;
        chk("t5_timed_out", 32'(n_tmo - b_tmo), 32'd1);
        chk("t5_err_set", 32'(err_o), 32'd1);
        wait_idle(2000);
        chk("t5_wr_attempts", 32'(n_wr_acc - b_acc), 32'd2);
        chk("t5_writes", 32'(n_wr - b_wr), 32'd1);
        chk("t5_err_sticky", 32'(err_o), 32'd1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        #2 chk("t5_err_cleared", 32'(err_o), 32'd0);

        // bus error while clear is held: set wins, then clear takes effect
        b_wr = n_wr;
        err_clr = 1'b1;
        err_once = 1;
        push_wait(8'h88);
        t = 0;
        while (!wb_err && t < 200) begin @(negedge clk); #2; t++; end
        chk("t5b_err_seen", 32'(wb_err), 32'd1);
        @(negedge clk); #2;
        chk("t5b_set_wins", 32'(err_o), 32'd1);
        @(negedge clk); #2;
        chk("t5b_clear_held", 32'(err_o), 32'd0);
        err_clr = 1'b0;
        wait_idle(2000);
        chk("t5b_writes", 32'(n_wr - b_wr), 32'd1);

        // reset while a write awaits its ack
        wr_noack = 1;
        push_wait(8'h99);
        t = 0;
        while (!(out_v && out_we) && t < 500) begin @(negedge clk); #2; t++; end
        chk("t6_in_wr_wait", 32'(out_v && out_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_cyc_drop", 32'(wb_cyc), 32'd0);
        chk("t6_stb_drop", 32'(wb_stb), 32'd0);
        chk("t6_qempty", 32'(q_empty), 32'd1);
        chk("t6_ready", 32'(s_ready), 32'd1);
        exp_q.delete();
        b_acc = n_wr_acc;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_noack = 0;
        repeat (60) @(negedge clk);
        #2;
        chk("t6_no_write_after", 32'(n_wr_acc - b_acc), 32'd0);
        chk("t6_still_empty", 32'(q_empty), 32'd1);
        chk("t6_err_clear", 32'(err_o), 32'd0);

        // randomized traffic with stalls, latencies, full polls and stray acks
        b_wr = n_wr;
        rand_mode = 1;
        for (int i = 0; i < 48; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_wait(8'($urandom));
        end
        wait_idle(20000);
        rand_mode = 0;
        chk("t7_writes", 32'(n_wr - b_wr), 32'd48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
